// File: rtl/icache_fetch_stage_if.sv
// Fetch-stage bus bundle: PC requests, cache-array read/fill ports, memory line fetch, instruction output.
// With ICACHE_FETCH_PERF_EN defined, the hit/miss counters are carried as well.
interface icache_fetch_stage_if #(
  parameter int ASSOC      = 4,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16,
  parameter int PC_WIDTH   = 32
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = PC_WIDTH - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WAY_W  = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  logic [PC_WIDTH-1:0]     i_pc;
  logic                    i_pc_valid;
  logic                    o_stall;
  logic                    i_flush;
  logic                    o_cache_read;
  logic [PC_WIDTH-1:0]     o_cache_pc;
  logic [ASSOC-1:0]        i_tag_valid;
  logic [ASSOC*TAG_W-1:0]  i_tag;
  logic [ASSOC*LINE_W-1:0] i_data;
  logic                    o_instr_valid;
  logic [31:0]             o_instr;
  logic [PC_WIDTH-1:0]     o_instr_pc;
  logic                    o_mem_req;
  logic [PC_WIDTH-1:0]     o_mem_addr;
  logic                    i_mem_ack;
  logic [LINE_W-1:0]       i_mem_line;
  logic                    o_fill_en;
  logic [WAY_W-1:0]        o_fill_way;
  logic [IDX_W-1:0]        o_fill_set;
  logic [TAG_W-1:0]        o_fill_tag;
  logic [LINE_W-1:0]       o_fill_line;
`ifdef ICACHE_FETCH_PERF_EN
  logic [31:0]             o_hit_cnt;
  logic [31:0]             o_miss_cnt;
`endif

  // Fetch stage side.
  modport slave (
    input  i_pc, i_pc_valid, i_flush, i_tag_valid, i_tag, i_data, i_mem_ack, i_mem_line,
    output o_stall, o_cache_read, o_cache_pc, o_instr_valid, o_instr, o_instr_pc,
           o_mem_req, o_mem_addr, o_fill_en, o_fill_way, o_fill_set, o_fill_tag, o_fill_line
`ifdef ICACHE_FETCH_PERF_EN
   ,output o_hit_cnt, o_miss_cnt
`endif
  );

  // Surrounding pipeline, arrays and memory side.
  modport master (
    output i_pc, i_pc_valid, i_flush, i_tag_valid, i_tag, i_data, i_mem_ack, i_mem_line,
    input  o_stall, o_cache_read, o_cache_pc, o_instr_valid, o_instr, o_instr_pc,
           o_mem_req, o_mem_addr, o_fill_en, o_fill_way, o_fill_set, o_fill_tag, o_fill_line
`ifdef ICACHE_FETCH_PERF_EN
   ,input  o_hit_cnt, o_miss_cnt
`endif
  );
endinterface

// File: rtl/icache_fetch_stage.sv
// Instruction-cache fetch stage: set read, next-cycle tag compare, miss fetch/fill/replay.
// Optional hit/miss counters are enabled with ICACHE_FETCH_PERF_EN.
module icache_fetch_stage #(
  parameter int ASSOC      = 4,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  icache_fetch_stage_if.slave   bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = PC_WIDTH - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WAY_W  = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_MISS_REQ, ST_DRAIN, ST_FILL, ST_REPLAY
  } state_t;

  state_t              state_q, state_d;
  logic                cmp_valid_q;
  logic [PC_WIDTH-1:0] cmp_pc_q;
  logic [WAY_W-1:0]    victim_q;
  logic                victim_rr_q;
  logic [WAY_W-1:0]    rr_ptr_q;
  logic [LINE_W-1:0]   line_q;

  logic [IDX_W-1:0]    cmp_idx;
  logic [TAG_W-1:0]    cmp_tag;
  logic [WSEL_W-1:0]   word_sel;
  logic                hit;
  logic [LINE_W-1:0]   hit_line;
  logic [WORDS-1:0][31:0] hit_words;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    victim;

  logic in_lookup, cmp_live, cmp_hit, cmp_miss, stall, accept, replay_rd;

  assign cmp_idx  = cmp_pc_q[OFF_W+IDX_W-1:OFF_W];
  assign cmp_tag  = cmp_pc_q[PC_WIDTH-1:OFF_W+IDX_W];
  assign word_sel = (WORDS > 1) ? cmp_pc_q[2 +: WSEL_W] : '0;

  // Scan from the top way down so the lowest matching / invalid way is the one kept.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    hit       = 1'b0;
    hit_line  = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (bus.i_tag_valid[w] && (bus.i_tag[w*TAG_W +: TAG_W] == cmp_tag)) begin
        hit      = 1'b1;
        hit_line = bus.i_data[w*LINE_W +: LINE_W];
      end
      if (!bus.i_tag_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign hit_words = hit_line;
  assign victim    = inv_found ? inv_way : rr_ptr_q;

  assign in_lookup = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cmp_live  = cmp_valid_q && in_lookup && !bus.i_flush;
  assign cmp_hit   = cmp_live && hit;
  assign cmp_miss  = cmp_live && !hit;
  assign stall     = !in_lookup || cmp_miss;
  assign accept    = bus.i_pc_valid && !stall && !bus.i_flush;
  assign replay_rd = (state_q == ST_REPLAY) && !bus.i_flush;

  assign bus.o_stall       = stall;
  assign bus.o_cache_read  = accept || replay_rd;
  assign bus.o_cache_pc    = accept ? bus.i_pc : (replay_rd ? cmp_pc_q : '0);
  assign bus.o_instr_valid = cmp_hit;
  assign bus.o_instr       = cmp_hit ? hit_words[word_sel] : '0;
  assign bus.o_instr_pc    = cmp_hit ? cmp_pc_q : '0;
  assign bus.o_mem_req     = (state_q == ST_MISS_REQ) || (state_q == ST_DRAIN);
  assign bus.o_mem_addr    = bus.o_mem_req ? {cmp_pc_q[PC_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.o_fill_en     = (state_q == ST_FILL);
  assign bus.o_fill_way    = bus.o_fill_en ? victim_q : '0;
  assign bus.o_fill_set    = bus.o_fill_en ? cmp_idx : '0;
  assign bus.o_fill_tag    = bus.o_fill_en ? cmp_tag : '0;
  assign bus.o_fill_line   = bus.o_fill_en ? line_q : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (bus.i_flush)   state_d = ST_IDLE;
        else if (cmp_miss) state_d = ST_MISS_REQ;
        else if (accept)   state_d = ST_RUN;
      end
      // A flushed miss still owns the outstanding memory request until its ack.
      ST_MISS_REQ: begin
        if (bus.i_flush)        state_d = bus.i_mem_ack ? ST_IDLE : ST_DRAIN;
        else if (bus.i_mem_ack) state_d = ST_FILL;
      end
      ST_DRAIN:  if (bus.i_mem_ack) state_d = ST_IDLE;
      ST_FILL:   state_d = bus.i_flush ? ST_IDLE : ST_REPLAY;
      ST_REPLAY: state_d = bus.i_flush ? ST_IDLE : ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous: it is sampled on the clock edge like any other input.
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cmp_valid_q <= 1'b0;
      cmp_pc_q    <= '0;
      victim_q    <= '0;
      victim_rr_q <= 1'b0;
      rr_ptr_q    <= '0;
      line_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      state_q     <= state_d;
      cmp_valid_q <= accept || replay_rd;
      if (accept) cmp_pc_q <= bus.i_pc;
      if (cmp_miss) begin
        victim_q    <= victim;
        victim_rr_q <= !inv_found;
      end
      if ((state_q == ST_MISS_REQ) && bus.i_mem_ack) line_q <= bus.i_mem_line;
      if ((state_q == ST_FILL) && victim_rr_q)
        rr_ptr_q <= (rr_ptr_q == WAY_W'(ASSOC - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
  end

`ifdef ICACHE_FETCH_PERF_EN
  logic        cmp_replay_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Replay hits complete a miss that was already counted, so they are excluded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmp_replay_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      cmp_replay_q <= replay_rd;
      if (cmp_hit && !cmp_replay_q)                         hit_cnt_q  <= hit_cnt_q + 32'd1;
      if ((state_q != ST_MISS_REQ) && (state_d == ST_MISS_REQ)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.o_hit_cnt  = hit_cnt_q;
  assign bus.o_miss_cnt = miss_cnt_q;
`endif

endmodule
